// File: rtl/tri_bus_pkg.sv
// Shared definitions for the three-state bus responder: FSM encoding,
// default bus width and the all-Z release value.
package tri_bus_pkg;

   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WR_ACK  = 2'd1,
      ST_RD_TURN = 2'd2,
      ST_RD_ACK  = 2'd3
   } state_e;

   localparam logic [DATA_W_DEF-1:0] BUS_RELEASE = {DATA_W_DEF{1'bz}};

endpackage : tri_bus_pkg

// File: rtl/tri_bus_pad.sv
// Per-bit enable buffers onto the shared data bus, plus a read-back tap
// so the write path sees whatever is currently on the wires.
module tri_bus_pad #(
   parameter int DATA_W = 32
) (
   input  logic              en_i,
   input  logic [DATA_W-1:0] data_i,
   inout  wire  [DATA_W-1:0] pad_io,
   output logic [DATA_W-1:0] tap_o
);

   for (genvar gi = 0; gi < DATA_W; gi++) begin : g_buf
      bufif1 u_buf (pad_io[gi], data_i[gi], en_i);
   end

   assign tap_o = pad_io;

endmodule : tri_bus_pad

// File: rtl/tri_bus_responder.sv
// Target end of the shared three-state bus: four-phase req/ack handshake,
// register-file writes and turnaround-protected reads.
module tri_bus_responder
   import tri_bus_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              bus_req,
   input  logic              bus_wr,
   input  logic [ADDR_W-1:0] bus_addr,
   inout  wire  [DATA_W-1:0] data_bus,
   output logic              bus_ack,
   output logic              bus_err,
   output logic              busy
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   state_e            state_q;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rd_q;
   logic              ack_q;
   logic              err_q;
   logic              busy_q;
   logic              drive_q;
   logic [DATA_W-1:0] tap_s;
   logic              oor_s;
   logic [IDX_W-1:0]  idx_s;

   tri_bus_pad #(.DATA_W(DATA_W)) u_pad (
      .en_i   (drive_q),
      .data_i (rd_q),
      .pad_io (data_bus),
      .tap_o  (tap_s)
   );

   // Address decode for the request currently on the bus.
   always_comb begin
      oor_s = 1'b0;
      idx_s = bus_addr[IDX_W-1:0];
      if ({1'b0, bus_addr} >= (ADDR_W+1)'(DEPTH)) begin
         oor_s = 1'b1;
      end else begin
         oor_s = 1'b0;
      end
   end

   // Handshake FSM, register file and all registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         rd_q    <= {DATA_W{1'b0}};
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         drive_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {DATA_W{1'b0}};
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus_req) begin
                  err_q  <= oor_s;
                  busy_q <= 1'b1;
                  if (bus_wr) begin
                     if (!oor_s) begin
                        mem_q[idx_s] <= tap_s;
                     end
                     ack_q   <= 1'b1;
                     state_q <= ST_WR_ACK;
                  end else begin
                     rd_q    <= oor_s ? {DATA_W{1'b0}} : mem_q[idx_s];
                     state_q <= ST_RD_TURN;
                  end
               end
            end
            // Turnaround: the initiator must stop driving before we start.
            ST_RD_TURN: begin
               if (bus_req) begin
                  ack_q   <= 1'b1;
                  drive_q <= 1'b1;
                  state_q <= ST_RD_ACK;
               end else begin
                  err_q   <= 1'b0;
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            ST_WR_ACK, ST_RD_ACK: begin
               if (!bus_req) begin
                  ack_q   <= 1'b0;
                  err_q   <= 1'b0;
                  busy_q  <= 1'b0;
                  drive_q <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               ack_q   <= 1'b0;
               err_q   <= 1'b0;
               busy_q  <= 1'b0;
               drive_q <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus_ack = ack_q;
   assign bus_err = err_q;
   assign busy    = busy_q;

endmodule : tri_bus_responder
